// File: rtl/adder16_rr_arbiter.sv
// adder16_rr_arbiter: one shared 16-bit ripple-carry adder serving NREQ
// requesters. A round-robin arbiter picks at most one requester per cycle,
// and its result is held in a single output register behind a valid/ready
// handshake.

// 16-bit ripple-carry adder: a + b + cin, carry out of bit 15.
module adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    // Ripple the carry from bit 0 up to bit 15.
    always_comb begin
        logic carry;
        // NOTE: blocking assignments in combinational logic, so each bit sees
        // the carry produced by the bit below it in the same evaluation.
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 16; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

module adder16_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_sum,
    output logic                 rsp_cout
);

    // Next index in the round-robin order; the last requester wraps to 0
    // explicitly so a non-power-of-two NREQ never lands on an unused index.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] x);
        return (x == IDW'(NREQ - 1)) ? '0 : x + IDW'(1);
    endfunction

    logic [IDW-1:0] prio;
    logic [IDW-1:0] winner;
    logic           found;
    logic           slot_free;
    logic           accept;
    logic [15:0]    op_a;
    logic [15:0]    op_b;
    logic [15:0]    add_sum;
    logic           add_cout;

    // The output register can take a new result when empty or being drained.
    assign slot_free = !rsp_valid || rsp_ready;
    // Requests are ignored while reset is held.
    assign accept    = found && slot_free && rst_n;

    // Scan from prio upward (with wrap) for the first valid requester.
    always_comb begin
        logic [IDW-1:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = prio;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
            cand = next_idx(cand);
        end
    end

    // One-hot ready toward the winner, only when its result can be stored.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Route the winner's operand pair to the shared adder.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                op_a = req_a[16*i +: 16];
                op_b = req_b[16*i +: 16];
            end
        end
    end

    adder16 u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Result register and round-robin pointer; prio only moves on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the result fields are reset along with rsp_valid so the
        // response outputs read as zero until the first grant.
        if (!rst_n) begin
            prio      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else if (accept) begin
            prio      <= next_idx(winner);
            rsp_valid <= 1'b1;
            rsp_id    <= winner;
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder16_rr_arbiter.sv
// Bench for adder16_rr_arbiter: directed vectors with literal expectations,
// plus a cycle-by-cycle comparison against a behavioural model.
module tb_adder16_rr_arbiter;

    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic [15:0]          rsp_sum;
    logic                 rsp_cout;

    // Second instance with three requesters for the explicit-wrap case.
    logic [2:0]           req_valid3;
    logic [2:0]           req_ready3;
    logic [47:0]          req_a3;
    logic [47:0]          req_b3;
    logic                 rsp_valid3;
    logic [1:0]           rsp_id3;
    logic [15:0]          rsp_sum3;
    logic                 rsp_cout3;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    adder16_rr_arbiter #(.NREQ(NREQ)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    adder16_rr_arbiter #(.NREQ(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid3),
        .req_ready (req_ready3),
        .req_a     (req_a3),
        .req_b     (req_b3),
        .rsp_valid (rsp_valid3),
        .rsp_ready (1'b1),
        .rsp_id    (rsp_id3),
        .rsp_sum   (rsp_sum3),
        .rsp_cout  (rsp_cout3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_prio;
    logic            m_valid;
    int              m_id;
    logic [15:0]     m_sum;
    logic            m_cout;
    logic [NREQ-1:0] m_ready;

    function automatic logic [NREQ-1:0] model_ready(input logic rst, input logic rdy,
                                                    input logic vld, input int p,
                                                    input logic [NREQ-1:0] rv);
        if (!rst) return '0;
        if (vld && !rdy) return '0;
        for (int k = 0; k < NREQ; k++) begin
            if (rv[(p + k) % NREQ]) return NREQ'(1) << ((p + k) % NREQ);
        end
        return '0;
    endfunction

    function automatic int win_of(input logic [NREQ-1:0] oh);
        for (int i = 0; i < NREQ; i++) if (oh[i]) return i;
        return 0;
    endfunction

    function automatic logic [16:0] sum_of(input logic [16*NREQ-1:0] a,
                                           input logic [16*NREQ-1:0] b, input int i);
        return 17'(a[16*i +: 16]) + 17'(b[16*i +: 16]);
    endfunction

    always_comb m_ready = model_ready(rst_n, rsp_ready, m_valid, m_prio, req_valid);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prio  <= 0;
            m_valid <= 1'b0;
            m_id    <= 0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
        end else if (m_ready != '0) begin
            m_valid          <= 1'b1;
            m_id             <= win_of(m_ready);
            {m_cout, m_sum}  <= sum_of(req_a, req_b, win_of(m_ready));
            m_prio           <= (win_of(m_ready) + 1) % NREQ;
        end else if (rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("mdl_ready", 32'(req_ready), 32'(m_ready));
            check("mdl_valid", 32'(rsp_valid), 32'(m_valid));
            check("mdl_id",    32'(rsp_id),    32'(m_id));
            check("mdl_sum",   32'(rsp_sum),   32'(m_sum));
            check("mdl_cout",  32'(rsp_cout),  32'(m_cout));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    initial begin
        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        req_valid  = 4'b1111;
        req_a      = '0;
        req_b      = '0;
        req_valid3 = '0;
        req_a3     = '0;
        req_b3     = '0;
        #2;
        cmp_en = 1'b1;

        // Reset state: requests ignored, response registers cleared.
        repeat (3) tick();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_id",    32'(rsp_id),    32'h0);
        check("rst_sum",   32'(rsp_sum),   32'h0);
        check("rst_cout",  32'(rsp_cout),  32'h0);
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        // Single request from requester 2.
        set_req(2, 16'h1234, 16'h0101);
        req_valid = 4'b0100;
        #1 check("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        check("single_valid", 32'(rsp_valid), 32'h1);
        check("single_id",    32'(rsp_id),    32'h2);
        check("single_sum",   32'(rsp_sum),   32'h1335);
        check("single_cout",  32'(rsp_cout),  32'h0);

        // Consumed with nothing new: valid drops, data holds.
        tick();
        check("drain_valid", 32'(rsp_valid), 32'h0);
        check("drain_sum",   32'(rsp_sum),   32'h1335);
        check("drain_id",    32'(rsp_id),    32'h2);

        // prio = 3, only requester 0 valid -> wrap to 0; overflow case.
        set_req(0, 16'hFFFF, 16'h0001);
        req_valid = 4'b0001;
        #1 check("wrap_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        check("ovf1_id",   32'(rsp_id),   32'h0);
        check("ovf1_sum",  32'(rsp_sum),  32'h0000);
        check("ovf1_cout", 32'(rsp_cout), 32'h1);

        // prio now 1: requester 1 beats requester 0.
        set_req(1, 16'h8000, 16'h8000);
        req_valid = 4'b0011;
        #1 check("prio1_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0001;
        check("ovf2_id",   32'(rsp_id),   32'h1);
        check("ovf2_sum",  32'(rsp_sum),  32'h0000);
        check("ovf2_cout", 32'(rsp_cout), 32'h1);
        #1 check("prio2_ready", 32'(req_ready), 32'b0001);
        tick();
        check("req0_id", 32'(rsp_id), 32'h0);

        // Grant requester 3 alone so prio returns to 0.
        req_valid = 4'b1000;
        tick();
        check("prep_id", 32'(rsp_id), 32'h3);

        // Full contention: ids rotate 0,1,2,3 with no bubbles.
        for (int i = 0; i < NREQ; i++) set_req(i, 16'(16'h1111 * i), 16'(16'h0100 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_valid", 32'(rsp_valid), 32'h1);
            check("rr_id",    32'(rsp_id),    32'(k % NREQ));
        end

        // Backpressure with requesters 1 and 3 pending.
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        #1 check("bp_ready0", 32'(req_ready), 32'h0);
        repeat (5) begin
            tick();
            check("bp_ready", 32'(req_ready), 32'h0);
            check("bp_valid", 32'(rsp_valid), 32'h1);
            check("bp_id",    32'(rsp_id),    32'h3);
            check("bp_sum",   32'(rsp_sum),   32'h3436);
        end
        rsp_ready = 1'b1;
        #1 check("rel_ready", 32'(req_ready), 32'b0010);
        tick();
        check("rel_id",  32'(rsp_id),  32'h1);
        check("rel_sum", 32'(rsp_sum), 32'h1212);
        req_valid = 4'b1000;
        #1 check("rel3_ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        check("rel3_id",  32'(rsp_id),  32'h3);
        check("rel3_sum", 32'(rsp_sum), 32'h3436);

        // Reset while a result is stalled.
        rsp_ready = 1'b0;
        tick();
        check("pre_rst_valid", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_sum",   32'(rsp_sum),   32'h0);
        req_valid = 4'b0101;
        rsp_ready = 1'b1;
        tick();
        check("in_rst_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        #1 check("post_rst_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0100;
        check("post_rst_id",  32'(rsp_id),  32'h0);
        check("post_rst_sum", 32'(rsp_sum), 32'h0100);
        tick();
        req_valid = '0;
        check("post_rst_id2",  32'(rsp_id),  32'h2);
        check("post_rst_sum2", 32'(rsp_sum), 32'h2324);

        // Three requesters: a grant to 2 wraps prio to 0.
        req_a3[32 +: 16] = 16'h0010;
        req_b3[32 +: 16] = 16'h0020;
        req_valid3 = 3'b100;
        #1 check("n3_ready2", 32'(req_ready3), 32'b100);
        tick();
        check("n3_valid", 32'(rsp_valid3), 32'h1);
        check("n3_id2",   32'(rsp_id3),    32'h2);
        check("n3_sum",   32'(rsp_sum3),   32'h0030);
        check("n3_cout",  32'(rsp_cout3),  32'h0);
        req_valid3 = 3'b101;
        #1 check("n3_wrap_ready", 32'(req_ready3), 32'b001);
        tick();
        req_valid3 = '0;
        check("n3_id0", 32'(rsp_id3), 32'h0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder16_rr_arbiter.md
# adder16_rr_arbiter

Shares one 16-bit ripple-carry adder (`adder16`, instantiated internally) between `NREQ` independent requesters. Arbitration is round-robin, and each requester has a valid/ready handshake. The block registers one result together with the requester index that produced it, and uses a valid/ready handshake on the response side. It sits between NPU processing-element lanes and the shared adder datapath.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters. Legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester index. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  bit i: requester i presents an operand pair.
- `req_ready`  out  NREQ  bit i: requester i's operands are accepted this cycle. At most one bit is high.
- `req_a`  in  16*NREQ  operand A; requester i uses bits [16*i+15:16*i].
- `req_b`  in  16*NREQ  operand B; same packing as `req_a`.
- `rsp_valid`  out  1  result register holds an unconsumed result.
- `rsp_ready`  in  1  consumer takes the result this cycle.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_sum`  out  16  `(a + b) mod 2^16`.
- `rsp_cout`  out  1  carry out of bit 15.

## Operation
- **Slot free:** `slot_free = !rsp_valid || rsp_ready`.
- **Round-robin pointer:** `prio`, IDW bits, reset 0, names the highest-priority requester.
- **Grant:** the winner is the first index with `req_valid` high, scanning `prio, prio+1, …, NREQ-1, 0, …, prio-1` (wraps modulo NREQ).
  - Grant is combinational from `req_valid` and `prio`.
  - `req_ready[winner] = slot_free`; all other `req_ready` bits are 0.
  - If no `req_valid` bit is high, `req_ready` is all 0.
- **Acceptance:** a request is accepted when `req_valid[i] && req_ready[i]`. On acceptance:
  - The winner's `a`/`b` are routed through a mux to the adder.
  - `rsp_sum`, `rsp_cout` and `rsp_id` (set to the winner) load on the clock edge.
  - `rsp_valid` is set to 1.
  - `prio` is set to `(winner+1) mod NREQ`. For `NREQ` not a power of two, an index of `NREQ-1` wraps to 0 explicitly.
- **No acceptance but result consumed:** if `rsp_valid && rsp_ready` and nothing is accepted, `rsp_valid` is set to 0. `rsp_sum`, `rsp_cout` and `rsp_id` hold their last values.
- **Consume and accept in the same cycle:** `rsp_valid` stays 1 and the new result replaces the old one. No bubble is inserted.
- **Backpressure** (`rsp_valid && !rsp_ready`):
  - `req_ready` is all 0.
  - `prio` is frozen.
  - `rsp_*` are held stable.
- **Pointer update rule:** `prio` changes only on acceptance. Requests that are pending but blocked do not advance it.
- **Arithmetic:** the result is full 16-bit unsigned. Overflow is reported only through `rsp_cout`; there is no saturation.
- **Requester obligations:**
  - Hold `req_valid`, `req_a` and `req_b` stable until accepted.
  - `req_valid` must not depend combinationally on `req_ready`.

## Timing
- **Reset values:**
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 16'h0000, `rsp_cout` = 0, `prio` = 0.
  - `req_ready` is all 0, because `req_valid` is ignored while `rst_n` is low.
- **Reset in the middle of operation:** asserting `rst_n` low discards the held result immediately, without waiting for a clock edge. The first grant after reset release follows `prio` = 0.
- **Latency:** a request accepted in cycle t produces `rsp_valid` = 1 with its result in cycle t+1.
- **Throughput:** one result per cycle while `rsp_ready` = 1.
- **Fairness:** with all NREQ requesters continuously valid and `rsp_ready` = 1, grants rotate 0,1,…,NREQ-1,0,…. Each requester waits at most NREQ-1 accepted grants.
- **Combinational paths:** `req_valid`→`req_ready` and `rsp_ready`→`req_ready` are combinational. No output depends combinationally on `req_a` or `req_b`.

## Test plan
- **Single request:** after reset, requester 2 presents a=16'h1234, b=16'h0101 → `req_ready` = 4'b0100 in the same cycle; next cycle `rsp_valid` = 1, `rsp_id` = 2, `rsp_sum` = 16'h1335, `rsp_cout` = 0; afterwards `prio` = 3.
- **Full contention:** all 4 requesters valid continuously, `rsp_ready` = 1 → `rsp_id` sequence 0,1,2,3,0,1,… on consecutive cycles with no idle cycles.
- **Overflow:** a=16'hFFFF, b=16'h0001 → `rsp_sum` = 16'h0000, `rsp_cout` = 1. Also a=16'h8000, b=16'h8000 → `rsp_sum` = 16'h0000, `rsp_cout` = 1.
- **Backpressure:** hold `rsp_ready` = 0 for 5 cycles while requesters 1 and 3 are valid:
  - During the stall, `req_ready` = 0, the `rsp_*` outputs are stable and `prio` is unchanged.
  - On release, the first result is delivered, then requester 1 is granted ahead of requester 3 when `prio` ≤ 1.
- **Wrap and sparse requests:** `prio` = 3 with only requester 0 valid → requester 0 is granted and `prio` becomes 1. With `NREQ` = 3, a grant to requester 2 sets `prio` to 0.
- **Reset mid-flight:** assert `rst_n` low while `rsp_valid` = 1 and the response is stalled → `rsp_valid` = 0 before the next clock edge. After release, requesters 2 and 0 are both valid → requester 0 is granted first.
